// File: rtl/vreg_file_seq.sv
// Vector register file with an element sequencer feeding a NUM_PE-lane PE array.
// Optional macro VREG_SIGN_EXT_EN enables sign-extended operand padding when op_signed is set.
`timescale 1ns/1ps
module vreg_file_seq #(
  parameter int VLEN   = 128,
  parameter int NREGS  = 32,
  parameter int NUM_PE = 4,
  parameter int ELEN   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [$clog2(NREGS)-1:0]   op_vs1,
  input  logic [$clog2(NREGS)-1:0]   op_vs2,
  input  logic [$clog2(NREGS)-1:0]   op_vd,
  input  logic [1:0]                 op_vsew,
  input  logic [$clog2(VLEN):0]      op_vl,
  input  logic                       op_widen,
  input  logic                       op_signed,
  output logic                       opd_valid,
  input  logic                       opd_ready,
  output logic [NUM_PE*ELEN-1:0]     opd_vs1,
  output logic [NUM_PE*ELEN-1:0]     opd_vs2,
  output logic [NUM_PE*ELEN-1:0]     opd_vs3,
  output logic [NUM_PE-1:0]          opd_mask,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [NUM_PE*ELEN-1:0]     res_data,
  output logic                       done,
  output logic                       err,
  input  logic                       ld_we,
  input  logic [$clog2(NREGS)-1:0]   ld_addr,
  input  logic [VLEN-1:0]            ld_data,
  input  logic [$clog2(NREGS)-1:0]   st_addr,
  output logic [VLEN-1:0]            st_data
);

  localparam int REG_W  = $clog2(NREGS);
  localparam int VL_W   = $clog2(VLEN) + 1;
  localparam int CNT_W  = VL_W + 1;
  localparam int BY_W   = CNT_W + 2;
  localparam int VB_W   = $clog2(VLEN / 8);
  localparam int BEAT_W = NUM_PE * ELEN;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                      state_q, state_d;
  logic [NREGS-1:0][VLEN-1:0]  rf_q;
  logic [CNT_W-1:0]            iss_q, iss_d;
  logic [CNT_W-1:0]            wb_q, wb_d;
  logic [REG_W-1:0]            vs1_q, vs2_q, vd_q;
  logic [1:0]                  vsew_q;
  logic [VL_W-1:0]             vl_q;
  logic                        widen_q;
  logic                        opd_valid_q, opd_valid_d;
  logic [BEAT_W-1:0]           opd_vs1_q, opd_vs2_q, opd_vs3_q;
  logic [NUM_PE-1:0]           opd_mask_q;
  logic                        done_q, done_d, err_q, err_d;
  logic                        latch, load_beat, wb_en;

  logic [REG_W-1:0]            c_vs1, c_vs2, c_vd;
  logic [1:0]                  c_sew, c_w3;
  logic [VL_W-1:0]             c_vl;
  logic                        c_widen, c_sx;
  logic [CNT_W-1:0]            c_e0, e_r;
  logic [REG_W-1:0]            reg1, reg2, reg3;
  logic [VB_W-1:0]             off_s, off_d;
  logic [BEAT_W-1:0]           beat_vs1, beat_vs2, beat_vs3;
  logic [NUM_PE-1:0]           beat_mask;

  logic [1:0]                  w_wc;
  logic [CNT_W-1:0]            e_w;
  logic [VB_W-1:0]             off_w;
  logic [REG_W-1:0]            wb_reg;
  logic [ELEN-1:0]             lm;
  logic [VLEN-1:0]             wb_data, wb_mask;

`ifdef VREG_SIGN_EXT_EN
  logic                        sgn_q;
`else
  logic                        unused_op_signed;
  assign unused_op_signed = op_signed;
`endif

  function automatic logic [ELEN-1:0] width_mask(input logic [1:0] wc);
    logic [ELEN-1:0] m;
    m = '0;
    for (int b = 0; b < ELEN; b++)
      if (b < (8 << wc)) m[b] = 1'b1;
    return m;
  endfunction

  // Pull one element out of a register and pad it to a full lane.
  function automatic logic [ELEN-1:0] lane_get(input logic [VLEN-1:0] r,
                                               input logic [VB_W-1:0] off,
                                               input logic [1:0]      wc,
                                               input logic            sx);
    logic [ELEN-1:0] raw, m, v;
    logic            msb;
    raw = ELEN'(r >> {off, 3'b000});
    m   = width_mask(wc);
    msb = 1'b0;
    for (int b = 0; b < ELEN; b++)
      if (b == (8 << wc) - 1) msb = raw[b];
    v = raw & m;
    if (sx && msb) v = v | ~m;
    return v;
  endfunction

  // In IDLE the beat is built straight from the request so beat 0 is valid right after acceptance.
  always_comb begin
    c_vs1   = vs1_q;
    c_vs2   = vs2_q;
    c_vd    = vd_q;
    c_sew   = vsew_q;
    c_vl    = vl_q;
    c_widen = widen_q;
    c_e0    = iss_q;
    c_sx    = 1'b0;
`ifdef VREG_SIGN_EXT_EN
    c_sx    = sgn_q;
`endif
    if (state_q == S_IDLE) begin
      c_vs1   = op_vs1;
      c_vs2   = op_vs2;
      c_vd    = op_vd;
      c_sew   = op_vsew;
      c_vl    = op_vl;
      c_widen = op_widen;
      c_e0    = '0;
`ifdef VREG_SIGN_EXT_EN
      c_sx    = op_signed;
`endif
    end
    c_w3 = c_widen ? 2'(c_sew + 2'd1) : c_sew;
    reg1 = c_vs1 + REG_W'((BY_W'(c_e0) << c_sew) >> VB_W);
    reg2 = c_vs2 + REG_W'((BY_W'(c_e0) << c_sew) >> VB_W);
    reg3 = c_vd  + REG_W'((BY_W'(c_e0) << c_w3) >> VB_W);
    beat_vs1  = '0;
    beat_vs2  = '0;
    beat_vs3  = '0;
    beat_mask = '0;
    e_r       = '0;
    off_s     = '0;
    off_d     = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      e_r = c_e0 + CNT_W'(i);
      if (e_r < CNT_W'(c_vl)) begin
        off_s = VB_W'(BY_W'(e_r) << c_sew);
        off_d = VB_W'(BY_W'(e_r) << c_w3);
        beat_vs1[i*ELEN +: ELEN] = lane_get(rf_q[reg1], off_s, c_sew, c_sx);
        beat_vs2[i*ELEN +: ELEN] = lane_get(rf_q[reg2], off_s, c_sew, c_sx);
        beat_vs3[i*ELEN +: ELEN] = lane_get(rf_q[reg3], off_d, c_w3, c_sx);
        beat_mask[i] = 1'b1;
      end
    end
  end

  // A whole beat lands in one register, so write-back is a single byte-masked update.
  always_comb begin
    w_wc    = widen_q ? 2'(vsew_q + 2'd1) : vsew_q;
    wb_reg  = vd_q + REG_W'((BY_W'(wb_q) << w_wc) >> VB_W);
    lm      = width_mask(w_wc);
    wb_data = '0;
    wb_mask = '0;
    e_w     = '0;
    off_w   = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      e_w = wb_q + CNT_W'(i);
      if (e_w < CNT_W'(vl_q)) begin
        off_w   = VB_W'(BY_W'(e_w) << w_wc);
        wb_data = wb_data | (VLEN'(res_data[i*ELEN +: ELEN] & lm) << {off_w, 3'b000});
        wb_mask = wb_mask | (VLEN'(lm) << {off_w, 3'b000});
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    iss_d       = iss_q;
    wb_d        = wb_q;
    opd_valid_d = opd_valid_q;
    latch       = 1'b0;
    load_beat   = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    wb_en       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          latch = 1'b1;
          if (op_vsew == 2'd3 || (op_widen && op_vsew == 2'd2)) begin
            err_d = 1'b1;
          end else if (op_vl == '0) begin
            done_d = 1'b1;
          end else begin
            load_beat   = 1'b1;
            opd_valid_d = 1'b1;
            iss_d       = CNT_W'(NUM_PE);
            wb_d        = '0;
            state_d     = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!opd_valid_q || opd_ready) begin
          if (iss_q < CNT_W'(vl_q)) begin
            load_beat   = 1'b1;
            opd_valid_d = 1'b1;
            iss_d       = iss_q + CNT_W'(NUM_PE);
          end else begin
            opd_valid_d = 1'b0;
            state_d     = S_DRAIN;
          end
        end
      end
      default: ;
    endcase
    if (res_ready && res_valid) begin
      wb_en = 1'b1;
      wb_d  = wb_q + CNT_W'(NUM_PE);
      if (wb_q + CNT_W'(NUM_PE) >= CNT_W'(vl_q)) begin
        done_d      = 1'b1;
        opd_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      iss_q       <= '0;
      wb_q        <= '0;
      vs1_q       <= '0;
      vs2_q       <= '0;
      vd_q        <= '0;
      vsew_q      <= '0;
      vl_q        <= '0;
      widen_q     <= 1'b0;
      opd_valid_q <= 1'b0;
      opd_vs1_q   <= '0;
      opd_vs2_q   <= '0;
      opd_vs3_q   <= '0;
      opd_mask_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef VREG_SIGN_EXT_EN
      sgn_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      iss_q       <= iss_d;
      wb_q        <= wb_d;
      opd_valid_q <= opd_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      if (latch) begin
        vs1_q   <= op_vs1;
        vs2_q   <= op_vs2;
        vd_q    <= op_vd;
        vsew_q  <= op_vsew;
        vl_q    <= op_vl;
        widen_q <= op_widen;
`ifdef VREG_SIGN_EXT_EN
        sgn_q   <= op_signed;
`endif
      end
      if (load_beat) begin
        opd_vs1_q  <= beat_vs1;
        opd_vs2_q  <= beat_vs2;
        opd_vs3_q  <= beat_vs3;
        opd_mask_q <= beat_mask;
      end
    end
  end

  // v0 is writable only through the load port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_q <= '0;
    end else if (ld_we && state_q == S_IDLE) begin
      rf_q[ld_addr] <= ld_data;
    end else if (wb_en && vd_q != '0) begin
      rf_q[wb_reg] <= (rf_q[wb_reg] & ~wb_mask) | (wb_data & wb_mask);
    end
  end

  assign op_ready  = (state_q == S_IDLE);
  assign res_ready = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign opd_valid = opd_valid_q;
  assign opd_vs1   = opd_vs1_q;
  assign opd_vs2   = opd_vs2_q;
  assign opd_vs3   = opd_vs3_q;
  assign opd_mask  = opd_mask_q;
  assign done      = done_q;
  assign err       = err_q;
  assign st_data   = rf_q[st_addr];

endmodule

// File: tb/tb_vreg_file_seq.sv
// Directed self-checking bench for vreg_file_seq (default parameters).
`timescale 1ns/1ps
module tb_vreg_file_seq;
  logic         clk = 1'b0;
  logic         reset;
  logic         op_valid, op_ready;
  logic [4:0]   op_vs1, op_vs2, op_vd;
  logic [1:0]   op_vsew;
  logic [7:0]   op_vl;
  logic         op_widen, op_signed;
  logic         opd_valid, opd_ready;
  logic [127:0] opd_vs1, opd_vs2, opd_vs3;
  logic [3:0]   opd_mask;
  logic         res_valid, res_ready;
  logic [127:0] res_data;
  logic         done, err;
  logic         ld_we;
  logic [4:0]   ld_addr, st_addr;
  logic [127:0] ld_data, st_data;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] V2 = 128'hFFEEDDCC_BBAA9988_77665544_04030201;
  localparam logic [127:0] V3 = 128'hDEADBEEF_CAFEF00D_13579BDF_2468ACE0;
  localparam logic [127:0] V4 = 128'h08080808_08080808_08080808_08080808;

  vreg_file_seq dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_vs1(op_vs1), .op_vs2(op_vs2), .op_vd(op_vd),
    .op_vsew(op_vsew), .op_vl(op_vl), .op_widen(op_widen), .op_signed(op_signed),
    .opd_valid(opd_valid), .opd_ready(opd_ready),
    .opd_vs1(opd_vs1), .opd_vs2(opd_vs2), .opd_vs3(opd_vs3), .opd_mask(opd_mask),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .done(done), .err(err),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .st_addr(st_addr), .st_data(st_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [4:0] a, input logic [127:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [127:0] exp);
    st_addr = a;
    #1;
    chk(tag, st_data, exp);
  endtask

  task automatic op_go(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                       input logic [1:0] sew, input logic [7:0] vl, input logic wd, input logic sg);
    op_vs1 = s1; op_vs2 = s2; op_vd = d; op_vsew = sew; op_vl = vl;
    op_widen = wd; op_signed = sg; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic res(input logic [127:0] d);
    res_valid = 1'b1; res_data = d;
    tick();
    res_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_vs1 = '0; op_vs2 = '0; op_vd = '0; op_vsew = '0;
    op_vl = '0; op_widen = 1'b0; op_signed = 1'b0; opd_ready = 1'b0; res_valid = 1'b0;
    res_data = '0; ld_we = 1'b0; ld_addr = '0; ld_data = '0; st_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_op_ready", op_ready, 1);
    chk("rst_opd_valid", opd_valid, 0);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_done_err", {done, err}, 0);
    rd("rst_v0", 0, 0);

    // basic SEW=8 op
    ld(2, V2); ld(3, V3); ld(4, V4);
    ld(6, 128'h11111111_22222222_33333333_44444444);
    op_go(2, 4, 6, 0, 4, 0, 0);
    chk("t1_valid", opd_valid, 1);
    chk("t1_op_ready", op_ready, 0);
    chk("t1_vs1", opd_vs1, 128'h00000004_00000003_00000002_00000001);
    chk("t1_vs2", opd_vs2, 128'h00000008_00000008_00000008_00000008);
    chk("t1_vs3", opd_vs3, 128'h00000044_00000044_00000044_00000044);
    chk("t1_mask", opd_mask, 4'b1111);
    opd_ready = 1'b1;
    tick();
    opd_ready = 1'b0;
    chk("t1_drain_valid", opd_valid, 0);
    chk("t1_res_ready", res_ready, 1);
    chk("t1_done_early", done, 0);
    res(128'hABCDEF0C_ABCDEF0B_ABCDEF0A_ABCDEF09);
    chk("t1_done", done, 1);
    rd("t1_v6", 6, 128'h11111111_22222222_33333333_0C0B0A09);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_op_ready_back", op_ready, 1);

    // SEW=32, vl=6 crossing into the second register of each group
    ld(7, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
    op_go(2, 4, 6, 2, 6, 0, 0);
    chk("t2_b0_vs1", opd_vs1, V2);
    chk("t2_b0_vs3", opd_vs3, 128'h11111111_22222222_33333333_0C0B0A09);
    chk("t2_b0_mask", opd_mask, 4'b1111);
    opd_ready = 1'b1;
    tick();
    chk("t2_b1_vs1", opd_vs1, 128'h00000000_00000000_13579BDF_2468ACE0);
    chk("t2_b1_vs2", opd_vs2, 128'h0);
    chk("t2_b1_vs3", opd_vs3, 128'h00000000_00000000_CCCCCCCC_DDDDDDDD);
    chk("t2_b1_mask", opd_mask, 4'b0011);
    tick();
    opd_ready = 1'b0;
    chk("t2_drain_valid", opd_valid, 0);
    res(128'h00000004_00000003_00000002_00000001);
    chk("t2_done_mid", done, 0);
    res(128'h99999999_88888888_00000006_00000005);
    chk("t2_done", done, 1);
    rd("t2_v6", 6, 128'h00000004_00000003_00000002_00000001);
    rd("t2_v7", 7, 128'hAAAAAAAA_BBBBBBBB_00000006_00000005);

    // widening SEW=8 -> 16, results overlapping issue
    ld(8, 128'h1107_1106_1105_1104_1103_1102_1101_1100);
    op_go(2, 4, 8, 0, 8, 1, 0);
    chk("t3_b0_vs1", opd_vs1, 128'h00000004_00000003_00000002_00000001);
    chk("t3_b0_vs3", opd_vs3, 128'h00001103_00001102_00001101_00001100);
    opd_ready = 1'b1;
    tick();
    chk("t3_b1_vs1", opd_vs1, 128'h00000077_00000066_00000055_00000044);
    chk("t3_b1_vs3", opd_vs3, 128'h00001107_00001106_00001105_00001104);
    res(128'hFFFFA003_FFFFA002_FFFFA001_FFFFA000);
    opd_ready = 1'b0;
    chk("t3_valid_after", opd_valid, 0);
    chk("t3_done_mid", done, 0);
    res(128'h0000B007_0000B006_0000B005_0000B004);
    chk("t3_done", done, 1);
    rd("t3_v8", 8, 128'hB007_B006_B005_B004_A003_A002_A001_A000);
    rd("t3_v9", 9, 128'h0);

    // v0 protection
    ld(0, 128'hFFFF);
    rd("t4_v0_load", 0, 128'hFFFF);
    op_go(2, 4, 0, 0, 4, 0, 0);
    opd_ready = 1'b1;
    tick();
    opd_ready = 1'b0;
    res(128'h12345678_12345678_12345678_12345678);
    chk("t4_done", done, 1);
    rd("t4_v0_kept", 0, 128'hFFFF);

    // back-pressure; load port ignored while busy
    op_go(3, 2, 10, 2, 4, 0, 0);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin ld_we = 1'b1; ld_addr = 11; ld_data = '1; end
      tick();
      ld_we = 1'b0;
      chk("t5_stall_valid", opd_valid, 1);
      chk("t5_stall_vs1", opd_vs1, V3);
      chk("t5_stall_vs2", opd_vs2, V2);
    end
    opd_ready = 1'b1;
    tick();
    opd_ready = 1'b0;
    chk("t5_valid_after", opd_valid, 0);
    res(128'h0000000D_0000000C_0000000B_0000000A);
    chk("t5_done", done, 1);
    rd("t5_v10", 10, 128'h0000000D_0000000C_0000000B_0000000A);
    rd("t5_v11_ignored", 11, 128'h0);

    // vl=0 and illegal ops
    op_go(2, 4, 6, 0, 0, 0, 0);
    chk("t6_vl0_done", done, 1);
    chk("t6_vl0_valid", opd_valid, 0);
    chk("t6_vl0_ready", op_ready, 1);
    tick();
    chk("t6_vl0_pulse", done, 0);
    op_go(2, 4, 6, 3, 4, 0, 0);
    chk("t6_sew3_err", err, 1);
    chk("t6_sew3_ready", op_ready, 1);
    chk("t6_sew3_valid", opd_valid, 0);
    tick();
    chk("t6_err_pulse", err, 0);
    op_go(2, 4, 6, 2, 4, 1, 0);
    chk("t6_widen32_err", err, 1);
    chk("t6_widen32_done", done, 0);
    tick();

    // padding and partial mask
    ld(13, 128'h01FF7F80);
    op_go(13, 13, 14, 0, 3, 0, 1);
`ifdef VREG_SIGN_EXT_EN
    chk("t7_pad_vs1", opd_vs1, 128'h00000000_FFFFFFFF_0000007F_FFFFFF80);
`else
    chk("t7_pad_vs1", opd_vs1, 128'h00000000_000000FF_0000007F_00000080);
`endif
    chk("t7_mask", opd_mask, 4'b0111);
    opd_ready = 1'b1;
    tick();
    opd_ready = 1'b0;
    res(128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
    chk("t7_done", done, 1);
    rd("t7_v14_tail", 14, 128'h00BBCCDD);

    // reset during DRAIN
    op_go(2, 4, 12, 0, 8, 0, 0);
    opd_ready = 1'b1;
    tick();
    tick();
    opd_ready = 1'b0;
    chk("t8_drain_res_ready", res_ready, 1);
    chk("t8_drain_op_ready", op_ready, 0);
    res(128'h00000004_00000003_00000002_00000001);
    rd("t8_v12_partial", 12, 128'h04030201);
    chk("t8_done_partial", done, 0);
    reset = 1'b1;
    #1;
    chk("t8_rst_res_ready", res_ready, 0);
    chk("t8_rst_valid", opd_valid, 0);
    chk("t8_rst_done_err", {done, err}, 0);
    rd("t8_rst_v12", 12, 128'h0);
    rd("t8_rst_v2", 2, 128'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("t8_op_ready", op_ready, 1);
    chk("t8_res_ready_idle", res_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
